// File: rtl/phy_pkg.sv
// Symbols and FSM state codes shared by the deserializer, receive link controller and IDLE transmitter.
package phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } phy_state_e;

  function automatic logic is_ctrl_sym(input logic [7:0] b);
    return (b == COM_SYM) || (b == IDL_SYM);
  endfunction

endpackage

// File: rtl/phy_rx_link_ctrl.sv
// Receive link controller: COM-count alignment, data forwarding with control strip, gap-timeout drop.
// Latency 1 cycle, all outputs registered; no backpressure (valid-only stream, downstream must accept).
// PHY_RX_CTRL_STATS_EN adds byte_cnt (wrapping) and loss_cnt (saturating) statistics ports.
module phy_rx_link_ctrl
  import phy_pkg::*;
#(
  parameter int COM_COUNT = 4,
  parameter int LOSS_MAX  = 16
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic [7:0] out,
  output logic       valid_out,
  output logic       active,
  output logic       lost_sync,
  output logic [1:0] state
`ifdef PHY_RX_CTRL_STATS_EN
  ,
  output logic [15:0] byte_cnt,
  output logic [7:0]  loss_cnt
`endif
);

  localparam logic [3:0] COM_TGT = 4'(COM_COUNT);
  localparam logic [7:0] GAP_TGT = 8'(LOSS_MAX);

  phy_state_e state_q, state_d;
  logic [3:0] com_cnt, com_cnt_d;
  logic [7:0] gap_cnt, gap_cnt_d;
  logic [7:0] out_d;
  logic       valid_out_d, lost_sync_d;
  logic       is_com;

  assign is_com = (in == COM_SYM);
  assign state  = state_q;

  always_comb begin
    state_d     = state_q;
    com_cnt_d   = com_cnt;
    gap_cnt_d   = gap_cnt;
    out_d       = out;
    valid_out_d = 1'b0;
    lost_sync_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid && is_com) begin
          com_cnt_d = 4'd1;
          state_d   = (COM_TGT == 4'd1) ? ST_ACTIVE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        // invalid cycles hold the run; only a valid non-COM breaks it
        if (valid && is_com) begin
          com_cnt_d = com_cnt + 4'd1;
          if (com_cnt_d == COM_TGT) state_d = ST_ACTIVE;
        end else if (valid) begin
          com_cnt_d = 4'd0;
          state_d   = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        com_cnt_d = 4'd0;
        if (valid) begin
          gap_cnt_d = 8'd0;
          if (!is_ctrl_sym(in)) begin
            out_d       = in;
            valid_out_d = 1'b1;
          end
        end else begin
          gap_cnt_d = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;
          if (gap_cnt_d == GAP_TGT) begin
            gap_cnt_d   = 8'd0;
            lost_sync_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        com_cnt_d = 4'd0;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      com_cnt   <= 4'd0;
      gap_cnt   <= 8'd0;
      out       <= 8'd0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      lost_sync <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt   <= com_cnt_d;
      gap_cnt   <= gap_cnt_d;
      out       <= out_d;
      valid_out <= valid_out_d;
      active    <= (state_d == ST_ACTIVE);
      lost_sync <= lost_sync_d;
    end
  end

`ifdef PHY_RX_CTRL_STATS_EN
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      byte_cnt <= 16'd0;
      loss_cnt <= 8'd0;
    end else begin
      if (valid_out_d) byte_cnt <= byte_cnt + 16'd1;
      if (lost_sync_d && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Bench for phy_rx_link_ctrl: vector table, corner sequences and a randomized run against a link model.
module tb_phy_rx_link_ctrl;

  localparam int COM_COUNT = 4;
  localparam int LOSS_MAX  = 16;

  logic       clk4f = 1'b0;
  logic       reset;
  logic [7:0] in_b;
  logic       valid;
  logic [7:0] out_b;
  logic       valid_out, active, lost_sync;
  logic [1:0] state;
`ifdef PHY_RX_CTRL_STATS_EN
  logic [15:0] byte_cnt;
  logic [7:0]  loss_cnt;
`endif

  phy_rx_link_ctrl #(.COM_COUNT(COM_COUNT), .LOSS_MAX(LOSS_MAX)) dut (
    .clk4f(clk4f), .reset(reset), .in(in_b), .valid(valid),
    .out(out_b), .valid_out(valid_out), .active(active),
    .lost_sync(lost_sync), .state(state)
`ifdef PHY_RX_CTRL_STATS_EN
    , .byte_cnt(byte_cnt), .loss_cnt(loss_cnt)
`endif
  );

  always #5 clk4f = ~clk4f;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Link model: counts a COM run while down, a valid-low run while up.
  bit         m_up;
  int         m_coms, m_gaps, m_bytes, m_losses;
  logic [7:0] m_last;
  logic       m_vo, m_lost;

  function automatic void model_reset();
    m_up = 0; m_coms = 0; m_gaps = 0; m_last = 8'h00;
    m_vo = 0; m_lost = 0; m_bytes = 0; m_losses = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d);
    m_vo = 0; m_lost = 0;
    if (!m_up) begin
      if (v) m_coms = (d == 8'hBC) ? m_coms + 1 : 0;
      if (m_coms == COM_COUNT) begin
        m_up = 1; m_coms = 0; m_gaps = 0;
      end
    end else if (v) begin
      m_gaps = 0;
      if (d != 8'hBC && d != 8'h7C) begin
        m_last = d; m_vo = 1; m_bytes = (m_bytes + 1) % 65536;
      end
    end else begin
      m_gaps++;
      if (m_gaps == LOSS_MAX) begin
        m_up = 0; m_gaps = 0; m_lost = 1;
        if (m_losses < 255) m_losses++;
      end
    end
  endfunction

  function automatic logic [1:0] m_state();
    return m_up ? 2'd2 : (m_coms > 0 ? 2'd1 : 2'd0);
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk4f);
    valid = v; in_b = d;
    model_step(v, d);
    @(posedge clk4f);
    #1;
    chk("out", 32'(out_b), 32'(m_last));
    chk("valid_out", 32'(valid_out), 32'(m_vo));
    chk("active", 32'(active), 32'(m_up));
    chk("lost_sync", 32'(lost_sync), 32'(m_lost));
    chk("state", 32'(state), 32'(m_state()));
`ifdef PHY_RX_CTRL_STATS_EN
    chk("byte_cnt", 32'(byte_cnt), 32'(m_bytes));
    chk("loss_cnt", 32'(loss_cnt), 32'(m_losses));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk4f);
    reset = 1'b1; valid = 1'b0; in_b = 8'h00;
    model_reset();
    @(negedge clk4f);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] e_out;
    logic       e_vo;
    logic       e_act;
    logic       e_lost;
    logic [1:0] e_st;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 8'hBC;
    if (r == 4) return 8'h7C;
    return 8'($urandom);
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[1]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[2]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[3]  = '{1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[6]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[7]  = '{1'b0, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[8]  = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 8'hBC, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[11] = '{1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[12] = '{1'b1, 8'h7C, 8'hA5, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[13] = '{1'b1, 8'hBC, 8'hA5, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[14] = '{1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[15] = '{1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 2'd2};

    reset = 1'b1; valid = 1'b0; in_b = 8'h00;
    model_reset();
    #1;
    chk("rst_out", 32'(out_b), 32'h00);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    @(negedge clk4f);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_out", i), 32'(out_b), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_vo", i), 32'(valid_out), 32'(tbl[i].e_vo));
      chk($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].e_act));
      chk($sformatf("tbl%0d_lost", i), 32'(lost_sync), 32'(tbl[i].e_lost));
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_st));
    end

    // 15 idle cycles survive, then a full LOSS_MAX gap drops the link
    step(1'b1, 8'h42);
    for (int i = 0; i < LOSS_MAX - 1; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    chk("gap15_active", 32'(active), 32'h1);
    chk("gap15_out", 32'(out_b), 32'h3C);
    for (int i = 0; i < LOSS_MAX - 1; i++) step(1'b0, 8'h00);
    chk("gap_pre_lost", 32'(lost_sync), 32'h0);
    step(1'b0, 8'h00);
    chk("gap16_lost", 32'(lost_sync), 32'h1);
    chk("gap16_active", 32'(active), 32'h0);
    chk("gap16_state", 32'(state), 32'h0);
    step(1'b0, 8'h00);
    chk("lost_one_shot", 32'(lost_sync), 32'h0);

    // asynchronous reset while ACTIVE with data on the output
    for (int i = 0; i < COM_COUNT; i++) step(1'b1, 8'hBC);
    step(1'b1, 8'h99);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out", 32'(out_b), 32'h00);
    chk("arst_valid_out", 32'(valid_out), 32'h0);
    chk("arst_active", 32'(active), 32'h0);
    chk("arst_lost", 32'(lost_sync), 32'h0);
    chk("arst_state", 32'(state), 32'h0);
    model_reset();
    @(negedge clk4f);
    reset = 1'b0;

`ifdef PHY_RX_CTRL_STATS_EN
    do_reset();
    for (int i = 0; i < COM_COUNT; i++) step(1'b1, 8'hBC);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1));
    for (int i = 0; i < LOSS_MAX; i++) step(1'b0, 8'h00);
    for (int i = 0; i < COM_COUNT; i++) step(1'b1, 8'hBC);
    step(1'b1, 8'h21);
    step(1'b1, 8'h22);
    chk("stats_bytes", 32'(byte_cnt), 32'd12);
    chk("stats_loss", 32'(loss_cnt), 32'd1);
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < COM_COUNT; i++) step(1'b1, 8'hBC);
      for (int i = 0; i < LOSS_MAX; i++) step(1'b0, 8'h00);
    end
    chk("stats_loss_sat", 32'(loss_cnt), 32'hFF);
`endif

    // randomized blocks with varying valid density to hit both data and timeouts
    do_reset();
    for (int blk = 0; blk < 60; blk++) begin
      int dens;
      dens = $urandom_range(0, 3);
      for (int i = 0; i < 50; i++) begin
        logic v;
        case (dens)
          0:       v = ($urandom_range(0, 9) == 0);
          1:       v = ($urandom_range(0, 1) == 0);
          default: v = ($urandom_range(0, 9) != 0);
        endcase
        step(v, rand_byte());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
